bus_burst_slave: RTL

BUS_BURST_SLAVE -- requirements
Module: bus_burst_slave

---
 rtl/bus_burst_slave.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bus_burst_slave.sv
// Burst-capable bus slave fronting an internal word RAM window.
// Reads stream one word per cycle after a short address check; writes accept one word per cycle after a single busy cycle.
module bus_burst_slave #(
    parameter logic [31:0] baseAddress = 32'h40000000,
    parameter int unsigned nrOfWords   = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic        endTransactionIn,
    input  logic        readNotWriteIn,
    input  logic        dataValidIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    input  logic [31:0] addressDataIn,
    output logic        endTransactionOut,
    output logic        dataValidOut,
    output logic        busyOut,
    output logic        busErrorOut,
    output logic [31:0] addressDataOut
);

    localparam int unsigned addrWidth = $clog2(nrOfWords);

    typedef enum logic [2:0] {
        IDLE, CHECK, READ, READ_END, WRITE, ERROR, ERROR_WAIT
    } stateT;

    stateT                 state;
    logic [31:0]           addressReg;
    logic                  readNotWrite;
    logic [3:0]            byteEnables;
    logic [7:0]            burstSize;
    logic [addrWidth-1:0]  wordAddr;
    logic [8:0]            beatCount;
    logic                  readPending;
    logic [31:0]           ramQ;
    logic [31:0]           mem [nrOfWords];

    logic [32:0] offset;
    logic [32:0] lastWord;
    logic        burstValid;
    logic [8:0]  beatLimit;
    logic        writeAccept;
    logic        readIssue;
    logic        readAbort;

    always_comb begin
        offset      = {1'b0, addressReg} - {1'b0, baseAddress};
        lastWord    = (offset >> 2) + 33'(burstSize);
        burstValid  = (addressReg[1:0] == 2'b00) && !offset[32] && (lastWord < 33'(nrOfWords));
        beatLimit   = {1'b0, burstSize} + 9'd1;
        writeAccept = (state == WRITE) && dataValidIn && !busyOut && (beatCount != beatLimit);
        readAbort   = (state == READ) && endTransactionIn;
        readIssue   = (state == READ) && !endTransactionIn;
    end

    // Single-port RAM; the read register is the first stage of the read pipeline.
    always_ff @(posedge clock) begin
        if (writeAccept) begin
            for (int unsigned lane = 0; lane < 4; lane++) begin
                if (byteEnables[lane]) begin
                    mem[wordAddr][lane*8 +: 8] <= addressDataIn[lane*8 +: 8];
                end
            end
        end
        ramQ <= mem[wordAddr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            addressReg        <= '0;
            readNotWrite      <= 1'b0;
            byteEnables       <= '0;
            burstSize         <= '0;
            wordAddr          <= '0;
            beatCount         <= '0;
            readPending       <= 1'b0;
            endTransactionOut <= 1'b0;
            dataValidOut      <= 1'b0;
            busyOut           <= 1'b0;
            busErrorOut       <= 1'b0;
            addressDataOut    <= '0;
        end else begin
            // An abort also squashes the word already fetched from RAM.
            readPending       <= readIssue;
            dataValidOut      <= readPending && !readAbort;
            addressDataOut    <= (readPending && !readAbort) ? ramQ : '0;
            endTransactionOut <= 1'b0;
            busErrorOut       <= 1'b0;
            case (state)
                IDLE: begin
                    if (beginTransactionIn) begin
                        addressReg   <= addressDataIn;
                        readNotWrite <= readNotWriteIn;
                        byteEnables  <= byteEnablesIn;
                        burstSize    <= burstSizeIn;
                        state        <= CHECK;
                    end
                end
                CHECK: begin
                    beatCount <= '0;
                    wordAddr  <= offset[2 +: addrWidth];
                    if (burstValid) begin
                        if (readNotWrite) begin
                            state <= READ;
                        end else begin
                            state   <= WRITE;
                            busyOut <= 1'b1;
                        end
                    end else begin
                        state       <= ERROR;
                        busErrorOut <= 1'b1;
                        busyOut     <= !readNotWrite;
                    end
                end
                READ: begin
                    if (endTransactionIn) begin
                        state <= IDLE;
                    end else begin
                        wordAddr  <= wordAddr + addrWidth'(1);
                        beatCount <= beatCount + 9'd1;
                        if (beatCount == {1'b0, burstSize}) begin
                            state <= READ_END;
                        end
                    end
                end
                READ_END: begin
                    // Hold off until the final word has left the pipeline.
                    if (!readPending) begin
                        endTransactionOut <= 1'b1;
                        state             <= IDLE;
                    end
                end
                WRITE: begin
                    busyOut <= 1'b0;
                    if (writeAccept) begin
                        wordAddr  <= wordAddr + addrWidth'(1);
                        beatCount <= beatCount + 9'd1;
                    end
                    if (endTransactionIn) begin
                        state <= IDLE;
                    end
                end
                ERROR: begin
                    state <= readNotWrite ? READ_END : ERROR_WAIT;
                end
                ERROR_WAIT: begin
                    if (endTransactionIn) begin
                        busyOut <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
